cla_sweep_checker: RTL
======================

Name: cla_sweep_checker

Overview:
- Synthesizable self-checking stimulus engine for the 4-bit carry-lookahead adder; it sits on the other side of the adder's a/b/c_in -> sum interface.
- Drives every operand combination in a fixed order: c_in outer, a middle, b inner.
- After a programmable settle delay it samples the adder's sum and compares it against an internal reference.
- Reports completion, pass/fail, mismatch count and the first failing vector, for on-chip/FPGA bring-up of the adder.

Parameters:
- WIDTH, 4, operand width; the sum is WIDTH+1 bits.
- SETTLE, 2, cycles operands are held before the sum is sampled; legal range >= 1.
- STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch; 0 = run the full sweep.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- a_out  out  WIDTH  operand a driven to the adder.
- b_out  out  WIDTH  operand b driven to the adder.
- c_out  out  1  carry-in driven to the adder.
- sum_in  in  WIDTH+1  adder result.
- busy  out  1  high in SETTLE or CHECK.
- done  out  1  high in DONE (level).
- pass  out  1  valid with done; 1 iff err_count == 0.
- err_count  out  2*WIDTH+2  number of mismatching vectors.
- fail_vec  out  3*WIDTH+2  first failing vector {c, a, b, sum_in}; 0 if none.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; a_out=b_out=c_out=0; busy=done=pass=0; err_count=0; fail_vec=0. Reset applies from any state, including mid-sweep; it discards all results.
- State IDLE: on start=1 -> load a=b=c=0, clear err_count, fail_vec and the first-fail flag; wait counter = SETTLE-1; go to SETTLE.
- State SETTLE: operands held. Decrement the wait counter; at 0 go to CHECK.
- State CHECK (one cycle):
  - Reference = a_out + b_out + c_out, zero-extended to WIDTH+1 bits, no overflow loss.
  - On mismatch: err_count += 1. If it is the first mismatch, capture fail_vec = {c_out, a_out, b_out, sum_in}.
  - Then:
    - If STOP_ON_FAIL=1 and a mismatch occurred -> DONE, operands held.
    - Else if {c,a,b} is all ones -> DONE, operands held.
    - Else increment {c,a,b} as one (2*WIDTH+1)-bit counter: b wraps to 0 and carries into a, a wraps and carries into c. Reload the wait counter and go to SETTLE.
- State DONE: done=1; pass = (err_count==0). On start=1, restart exactly as from IDLE; done falls on the same edge.
- start while busy: ignored, no effect.
- Vector count = 2^(2*WIDTH+1) = 512 for the defaults. Each vector takes SETTLE+1 cycles.
- Timing convention: cycle 0 is the first cycle after the edge that sampled start. Vector k is checked in cycle k*(SETTLE+1)+SETTLE. done rises 512*(SETTLE+1) = 1536 cycles after start for the defaults.
- err_count cannot overflow: its width holds 2^(2*WIDTH+1).
- sum_in is sampled only in CHECK; its value in other states is don't-care.

Test Plan:
- Ideal behavioural adder on the outputs, defaults, start pulse:
  - -> busy high from cycle 0 to cycle 1535; done=1 and pass=1 at cycle 1536; err_count=0; fail_vec=0.
  - -> Operand order check: a_out=1, b_out=15, c_out=0 during cycle 31*3.
- Adder with sum[4] stuck at 0:
  - -> err_count=256 (120 vectors with c=0, 136 with c=1); pass=0.
  - -> fail_vec={c=0, a=1, b=15, sum=5'h00}.
- Adder that ignores c_in:
  - -> err_count=256; fail_vec={c=1, a=0, b=0, sum=5'h00}.
- STOP_ON_FAIL=1 with sum[4] stuck at 0:
  - -> done at cycle 96 with err_count=1 and pass=0.
  - -> Operands held at a=1, b=15, c=0.
- Control and reset:
  - start pulsed at cycle 200 of a sweep -> ignored; done still at 1536.
  - rst_n=0 for one edge at cycle 700 -> all outputs 0, IDLE.
  - New start -> full 1536-cycle sweep, pass=1.
- Restart from DONE after a failing sweep, with the adder swapped to ideal -> err_count and fail_vec cleared at start; pass=1 at the end.

Source files
------------

// File: rtl/cla_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and the adder under test,
// plus the checker's control and result signals.
interface cla_sweep_checker_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a_out;
    logic [WIDTH-1:0]       b_out;
    logic                   c_out;
    logic [WIDTH:0]         sum_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [2*WIDTH+1:0]     err_count;
    logic [3*WIDTH+1:0]     fail_vec;

    modport master (
        input  start, sum_in,
        output a_out, b_out, c_out, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, sum_in,
        input  a_out, b_out, c_out, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/cla_sweep_checker.sv
// Exhaustive operand sweep for a WIDTH-bit adder: drives {c,a,b}, waits SETTLE
// cycles, compares sum_in against a reference and records errors.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | operands held, wait counter running down
// CHECK  | one cycle: compare sum_in, advance or finish
// DONE   | results valid, waiting for a new start
module cla_sweep_checker #(
    parameter int WIDTH        = 4,
    parameter int SETTLE       = 2,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_sweep_checker_if.master    bus
);

    localparam int VEC_W  = 2*WIDTH + 1;
    localparam int ERR_W  = 2*WIDTH + 2;
    localparam int FAIL_W = 3*WIDTH + 2;
    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [ERR_W-1:0]    err_q;
    logic [FAIL_W-1:0]   fail_vec_q;
    logic                fail_seen_q;

    logic [WIDTH-1:0]    a_cur, b_cur;
    logic                c_cur;
    logic [WIDTH:0]      ref_sum;
    logic                mismatch;
    logic                last_vec;
    logic                launch;

    // vec_q is {c, a, b}: one counter gives the c-outer, a-middle, b-inner order
    assign c_cur    = vec_q[2*WIDTH];
    assign a_cur    = vec_q[2*WIDTH-1:WIDTH];
    assign b_cur    = vec_q[WIDTH-1:0];
    assign ref_sum  = {1'b0, a_cur} + {1'b0, b_cur} + {{WIDTH{1'b0}}, c_cur};
    assign mismatch = (state_q == S_CHECK) && (bus.sum_in != ref_sum);
    assign last_vec = &vec_q;
    assign launch   = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_SETTLE;
            S_SETTLE: if (wait_q == '0) state_d = S_CHECK;
            S_CHECK: begin
                if ((STOP_ON_FAIL != 0 && mismatch) || last_vec) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_DONE:   if (bus.start) state_d = S_SETTLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.pass = 1'b0;
        case (state_q)
            S_SETTLE, S_CHECK: bus.busy = 1'b1;
            S_DONE: begin
                bus.done = 1'b1;
                bus.pass = (err_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q       <= '0;
            wait_q      <= '0;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_seen_q <= 1'b0;
        end else if (launch) begin
            vec_q       <= '0;
            wait_q      <= WAIT_LOAD;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_seen_q <= 1'b0;
        end else if (state_q == S_SETTLE) begin
            if (wait_q != '0) wait_q <= wait_q - WAIT_W'(1);
        end else if (state_q == S_CHECK) begin
            if (mismatch) begin
                err_q <= err_q + ERR_W'(1);
                if (!fail_seen_q) begin
                    fail_vec_q  <= {vec_q, bus.sum_in};
                    fail_seen_q <= 1'b1;
                end
            end
            // operands stay put when the sweep ends so the last vector remains visible
            if (state_d == S_SETTLE) begin
                vec_q  <= vec_q + VEC_W'(1);
                wait_q <= WAIT_LOAD;
            end
        end
    end

    assign bus.a_out     = a_cur;
    assign bus.b_out     = b_cur;
    assign bus.c_out     = c_cur;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_vec_q;

endmodule
